// File: rtl/snes_bus_master.sv
// SNES CPU-side bus cycle generator: turns single-byte REQ/ACK/DONE requests
// into 65816-style 6/8/12 master-clock bus cycles with /RD, /WR, /CART and CPU_CLK.
module snes_bus_master #(
  parameter int         CLK_PER_MCLK = 4,
  parameter logic [1:0] IDLE_SPEED   = 2'b01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WRITE,
  input  logic [23:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  input  logic [1:0]  REQ_SPEED,
  output logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  RDATA,
  output logic [23:0] SNES_ADDR_OUT,
  output logic        SNES_READ_OUT,
  output logic        SNES_WRITE_OUT,
  output logic        SNES_CS_OUT,
  output logic        SNES_CPU_CLK_OUT,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        SNES_DATA_OE,
  input  logic [7:0]  SNES_DATA_IN
);

  localparam int            LMAX     = 12 * CLK_PER_MCLK;
  localparam int            TW       = $clog2(LMAX);
  localparam logic [TW-1:0] STROBE_T = TW'(CLK_PER_MCLK);

  // S_START marks the first edge after reset, which is always a cycle boundary.
  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_IDLE  = 2'b01,
    S_READ  = 2'b10,
    S_WRITE = 2'b11
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] t_r, t_s;
  logic [TW-1:0] last_r, last_s;
  logic [TW-1:0] rise_r, rise_s;
  logic          boundary_s;
  logic          start_s;
  logic          access_end_s;

  // Last tick index of a cycle (L-1) for a speed code.
  function automatic logic [TW-1:0] last_tick(input logic [1:0] spd);
    case (spd)
      2'b00:   last_tick = TW'(6 * CLK_PER_MCLK - 1);
      2'b10:   last_tick = TW'(12 * CLK_PER_MCLK - 1);
      default: last_tick = TW'(8 * CLK_PER_MCLK - 1);
    endcase
  endfunction

  // Tick at which CPU_CLK rises: (N-4) master clocks into the cycle.
  function automatic logic [TW-1:0] rise_tick(input logic [1:0] spd);
    case (spd)
      2'b00:   rise_tick = TW'(2 * CLK_PER_MCLK);
      2'b10:   rise_tick = TW'(8 * CLK_PER_MCLK);
      default: rise_tick = TW'(4 * CLK_PER_MCLK);
    endcase
  endfunction

  // /CART decode: banks 40-FF except WRAM banks 7E/7F, or upper half of 00-3F/80-BF.
  function automatic logic cart_sel_n(input logic [7:0] bank, input logic a15);
    if (bank[6]) begin
      cart_sel_n = (bank[7:1] == 7'h3F);
    end else begin
      cart_sel_n = ~a15;
    end
  endfunction

  // Next-state: tick counter, cycle type and per-cycle timing selection.
  always_comb begin
    state_s      = state_r;
    t_s          = t_r;
    last_s       = last_r;
    rise_s       = rise_r;
    boundary_s   = (state_r == S_START) || (t_r == last_r);
    start_s      = boundary_s && REQ;
    access_end_s = boundary_s && ((state_r == S_READ) || (state_r == S_WRITE));
    if (boundary_s) begin
      t_s = '0;
      if (REQ) begin
        state_s = REQ_WRITE ? S_WRITE : S_READ;
        last_s  = last_tick(REQ_SPEED);
        rise_s  = rise_tick(REQ_SPEED);
      end else begin
        state_s = S_IDLE;
        last_s  = last_tick(IDLE_SPEED);
        rise_s  = rise_tick(IDLE_SPEED);
      end
    end else begin
      t_s = t_r + TW'(1);
    end
  end

  // Cycle state and timing registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_START;
      t_r     <= '0;
      last_r  <= last_tick(IDLE_SPEED);
      rise_r  <= rise_tick(IDLE_SPEED);
    end else begin
      state_r <= state_s;
      t_r     <= t_s;
      last_r  <= last_s;
      rise_r  <= rise_s;
    end
  end

  // Bus and handshake outputs, all derived from next-state so they line up with t.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ACK              <= 1'b0;
      BUSY             <= 1'b0;
      DONE             <= 1'b0;
      RDATA            <= 8'h00;
      SNES_ADDR_OUT    <= 24'h000000;
      SNES_READ_OUT    <= 1'b1;
      SNES_WRITE_OUT   <= 1'b1;
      SNES_CS_OUT      <= 1'b1;
      SNES_CPU_CLK_OUT <= 1'b0;
      SNES_DATA_OUT    <= 8'h00;
      SNES_DATA_OE     <= 1'b0;
    end else begin
      ACK              <= start_s;
      DONE             <= access_end_s;
      BUSY             <= (state_s == S_READ) || (state_s == S_WRITE);
      SNES_CPU_CLK_OUT <= (t_s >= rise_s);
      SNES_READ_OUT    <= ~((state_s == S_READ) && (t_s >= STROBE_T));
      SNES_WRITE_OUT   <= ~((state_s == S_WRITE) && (t_s >= STROBE_T));
      SNES_DATA_OE     <= (state_s == S_WRITE) && (t_s >= STROBE_T);

      // Read data is whatever the responder drives during the last tick.
      if (boundary_s && (state_r == S_READ)) begin
        RDATA <= SNES_DATA_IN;
      end else begin
        RDATA <= RDATA;
      end

      // Address and chip select change only at boundaries; idle cycles keep the address.
      if (start_s) begin
        SNES_ADDR_OUT <= REQ_ADDR;
        SNES_CS_OUT   <= cart_sel_n(REQ_ADDR[23:16], REQ_ADDR[15]);
      end else if (boundary_s) begin
        SNES_ADDR_OUT <= SNES_ADDR_OUT;
        SNES_CS_OUT   <= 1'b1;
      end else begin
        SNES_ADDR_OUT <= SNES_ADDR_OUT;
        SNES_CS_OUT   <= SNES_CS_OUT;
      end

      if (start_s && REQ_WRITE) begin
        SNES_DATA_OUT <= REQ_WDATA;
      end else begin
        SNES_DATA_OUT <= SNES_DATA_OUT;
      end
    end
  end

endmodule

// File: tb/tb_snes_bus_master.sv
// Self-checking bench for snes_bus_master: a responder model answers reads,
// a scoreboard queue holds expected read data and ACK-to-DONE latency per access.
module tb_snes_bus_master;

  localparam int P = 4;

  logic        CLK;
  logic        RST;
  logic        REQ;
  logic        REQ_WRITE;
  logic [23:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic [1:0]  REQ_SPEED;
  logic        ACK;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  RDATA;
  logic [23:0] SNES_ADDR_OUT;
  logic        SNES_READ_OUT;
  logic        SNES_WRITE_OUT;
  logic        SNES_CS_OUT;
  logic        SNES_CPU_CLK_OUT;
  logic [7:0]  SNES_DATA_OUT;
  logic        SNES_DATA_OE;
  logic [7:0]  SNES_DATA_IN;

  snes_bus_master #(.CLK_PER_MCLK(P), .IDLE_SPEED(2'b01)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_SPEED(REQ_SPEED), .ACK(ACK), .BUSY(BUSY), .DONE(DONE),
    .RDATA(RDATA), .SNES_ADDR_OUT(SNES_ADDR_OUT), .SNES_READ_OUT(SNES_READ_OUT),
    .SNES_WRITE_OUT(SNES_WRITE_OUT), .SNES_CS_OUT(SNES_CS_OUT),
    .SNES_CPU_CLK_OUT(SNES_CPU_CLK_OUT), .SNES_DATA_OUT(SNES_DATA_OUT),
    .SNES_DATA_OE(SNES_DATA_OE), .SNES_DATA_IN(SNES_DATA_IN)
  );

  typedef struct {
    logic [7:0] exp_rdata;
    int         len;
  } sb_item_t;

  sb_item_t   sb[$];
  int         ackq[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] model_rdata = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] resp_fn(input logic [23:0] a);
    resp_fn = a[23:16] ^ a[15:8] ^ a[7:0] ^ 8'h25;
  endfunction

  // Responder: drives data only while /RD is low.
  assign SNES_DATA_IN = (!SNES_READ_OUT) ? resp_fn(SNES_ADDR_OUT) : 8'hFF;

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'b00:   len_of = 6 * P;
      2'b10:   len_of = 12 * P;
      default: len_of = 8 * P;
    endcase
  endfunction

  function automatic int hi_of(input logic [1:0] s);
    case (s)
      2'b00:   hi_of = 2 * P;
      2'b10:   hi_of = 8 * P;
      default: hi_of = 4 * P;
    endcase
  endfunction

  function automatic logic cs_exp(input logic [23:0] a);
    logic [7:0] b;
    b = a[23:16];
    if (b[6]) cs_exp = (b == 8'h7E) || (b == 8'h7F);
    else      cs_exp = !a[15];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // DONE monitor: pops the scoreboard, checks read data and ACK-to-DONE latency.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DONE) begin
        if (sb.size() == 0) begin
          check_eq("done_unexpected", {31'd0, DONE}, 32'd0);
        end else begin
          sb_item_t it;
          int       a;
          it = sb.pop_front();
          a  = (ackq.size() > 0) ? ackq.pop_front() : -1000;
          check_eq("sb_rdata", {24'd0, RDATA}, {24'd0, it.exp_rdata});
          check_eq("sb_latency", cyc - a, it.len);
        end
      end
      if (ACK) ackq.push_back(cyc);
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_ctl"}, {24'd0, ACK, BUSY, DONE, SNES_READ_OUT, SNES_WRITE_OUT,
             SNES_CS_OUT, SNES_CPU_CLK_OUT, SNES_DATA_OE}, 32'h1C);
    check_eq({tag, "_addr"}, {8'd0, SNES_ADDR_OUT}, 32'd0);
    check_eq({tag, "_rdata"}, {24'd0, RDATA}, 32'd0);
    check_eq({tag, "_dout"}, {24'd0, SNES_DATA_OUT}, 32'd0);
  endtask

  task automatic start_req(input logic w, input logic [23:0] a, input logic [7:0] d,
                           input logic [1:0] s);
    sb_item_t it;
    REQ = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d; REQ_SPEED = s;
    if (!w) model_rdata = resp_fn(a);
    it.exp_rdata = model_rdata;
    it.len       = len_of(s);
    sb.push_back(it);
  endtask

  task automatic wait_ack(output int waited);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!ACK && waited < 100);
    check_eq("ack_seen", {31'd0, ACK}, 32'd1);
  endtask

  // Checks one access cycle; the current negedge is tick 0.
  task automatic check_cycle(input logic w, input logic [23:0] a, input logic [7:0] d,
                             input logic [1:0] s);
    int          l, hi;
    logic [31:0] obs, exp;
    l  = len_of(s);
    hi = hi_of(s);
    check_eq("cyc_addr", {8'd0, SNES_ADDR_OUT}, {8'd0, a});
    if (w) check_eq("cyc_wdata", {24'd0, SNES_DATA_OUT}, {24'd0, d});
    for (int j = 0; j < l; j++) begin
      if (j > 0) @(negedge CLK);
      obs = {26'd0, BUSY, SNES_CS_OUT, SNES_CPU_CLK_OUT, SNES_READ_OUT, SNES_WRITE_OUT,
             SNES_DATA_OE};
      exp = {26'd0, 1'b1, cs_exp(a), (j >= hi), (w ? 1'b1 : (j < P)),
             (w ? (j < P) : 1'b1), (w && (j >= P))};
      check_eq($sformatf("cyc_%s_t%0d", w ? "wr" : "rd", j), obs, exp);
    end
  endtask

  // Checks n idle ticks, advancing one negedge before each sample.
  task automatic check_idle(input int t0, input int n);
    int          t;
    logic [31:0] obs, exp;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      t   = (t0 + k) % (8 * P);
      obs = {25'd0, ACK, BUSY, SNES_CS_OUT, SNES_CPU_CLK_OUT, SNES_READ_OUT,
             SNES_WRITE_OUT, SNES_DATA_OE};
      exp = {25'd0, 1'b0, 1'b0, 1'b1, (t >= 4 * P), 1'b1, 1'b1, 1'b0};
      check_eq($sformatf("idle_t%0d", t), obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    RST = 1'b1; REQ = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = 24'h000000;
    REQ_WDATA = 8'h00; REQ_SPEED = 2'b00;
    repeat (3) @(negedge CLK);
    check_reset("rst_init");
    RST = 1'b0;
    check_idle(0, 64);

    // Read, speed 00; request inputs scrambled after ACK must be ignored.
    start_req(1'b0, 24'h008000, 8'h00, 2'b00);
    wait_ack(w);
    REQ = 1'b0; REQ_WRITE = 1'b1; REQ_ADDR = 24'hFFFFFF;
    check_cycle(1'b0, 24'h008000, 8'h00, 2'b00);
    @(negedge CLK);
    check_eq("rd_done", {31'd0, DONE}, 32'd1);
    check_eq("rd_rdata", {24'd0, RDATA}, 32'hA5);
    check_eq("rd_busy_end", {31'd0, BUSY}, 32'd0);

    // Write, speed 10, WRAM bank: /CART stays high.
    start_req(1'b1, 24'h7E0010, 8'h3C, 2'b10);
    wait_ack(w);
    REQ = 1'b0; REQ_WDATA = 8'h00;
    check_cycle(1'b1, 24'h7E0010, 8'h3C, 2'b10);
    @(negedge CLK);
    check_eq("wr_done", {31'd0, DONE}, 32'd1);
    check_eq("wr_rdata_held", {24'd0, RDATA}, 32'hA5);
    @(negedge CLK);
    check_eq("wr_done_once", {31'd0, DONE}, 32'd0);

    // Back-to-back reads.
    start_req(1'b0, 24'hC00000, 8'h00, 2'b00);
    wait_ack(w);
    start_req(1'b0, 24'h401234, 8'h00, 2'b01);
    check_cycle(1'b0, 24'hC00000, 8'h00, 2'b00);
    wait_ack(w);
    check_eq("b2b_gap", w, 1);
    check_eq("b2b_done", {31'd0, DONE}, 32'd1);
    REQ = 1'b0;
    check_cycle(1'b0, 24'h401234, 8'h00, 2'b01);
    @(negedge CLK);
    check_eq("b2b_done2", {31'd0, DONE}, 32'd1);

    // Reset at t=10 of a read aborts it without DONE.
    start_req(1'b0, 24'h009000, 8'h00, 2'b01);
    wait_ack(w);
    REQ = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset("rst_mid");
    sb.delete();
    ackq.delete();
    model_rdata = 8'h00;
    RST = 1'b0;
    check_idle(0, 40);

    // Speed 11 read, then a short REQ pulse inside an idle cycle.
    start_req(1'b0, 24'h00ABCD, 8'h00, 2'b11);
    wait_ack(w);
    REQ = 1'b0;
    check_cycle(1'b0, 24'h00ABCD, 8'h00, 2'b11);
    @(negedge CLK);
    check_eq("s11_done", {31'd0, DONE}, 32'd1);
    check_idle(1, 5);
    REQ = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 24'h008888; REQ_SPEED = 2'b00;
    check_idle(6, 4);
    REQ = 1'b0;
    check_idle(10, 60);

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_bus_master.md
Name: snes_bus_master

Overview:
- SNES CPU-side bus cycle generator; the initiator counterpart of the cartridge-side master control FSM.
- Drives address, /RD, /WR, /CART and CPU_CLK with 65816-like cycle timing (6/8/12 master clocks).
- Serves single-byte read/write requests from an internal requester through a REQ/ACK/DONE handshake.
- Used for on-board loopback self-test of the cart responder and SRAM path.

Parameters:
- CLK_PER_MCLK, 4, internal CLK cycles per SNES master clock (P); cycle length L = N*P.
- IDLE_SPEED, 2'b01, speed code used for idle (no-request) cycles.

Ports:
- CLK  in  1  system clock (posedge).
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  request pending (level).
- REQ_WRITE  in  1  1=write, 0=read.
- REQ_ADDR  in  24  access address.
- REQ_WDATA  in  8  write data.
- REQ_SPEED  in  2  00=6, 01=8, 10=12, 11=8 master clocks.
- ACK  out  1  one-CLK pulse: request latched.
- BUSY  out  1  access cycle in progress.
- DONE  out  1  one-CLK pulse: access finished.
- RDATA  out  8  read result, valid when DONE=1, held until the next read DONE.
- SNES_ADDR_OUT  out  24  bus address.
- SNES_READ_OUT  out  1  /RD, active low.
- SNES_WRITE_OUT  out  1  /WR, active low.
- SNES_CS_OUT  out  1  /CART, active low.
- SNES_CPU_CLK_OUT  out  1  CPU clock.
- SNES_DATA_OUT  out  8  write data.
- SNES_DATA_OE  out  1  drive SNES_DATA_OUT onto the bus.
- SNES_DATA_IN  in  8  bus data from the responder.

Behaviour:
- All outputs are registered.
- Reset values: ACK=0, BUSY=0, DONE=0, RDATA=0, ADDR_OUT=0, READ_OUT=1, WRITE_OUT=1, CS_OUT=1, CPU_CLK_OUT=0, DATA_OUT=0, DATA_OE=0; tick counter t=0.
- Cycle clocking: the first CLK edge after RST deasserts is a boundary edge.
- Tick counter t runs 0..L-1. Boundary edge = edge where t wraps L-1→0. N comes from the latched speed code.
- Cycle type at a boundary edge:
  - REQ=1: access cycle. Latch WRITE/ADDR/WDATA/SPEED, ACK=1 for that CLK, BUSY=1, ADDR_OUT=REQ_ADDR.
  - REQ=0: idle cycle with N from IDLE_SPEED. ADDR_OUT holds its last value, CS_OUT=1, strobes stay high, BUSY=0.
- CPU_CLK_OUT: 0 for t<(N-4)*P, 1 for the remainder of the cycle, in both access and idle cycles.
- CS_OUT during an access cycle (set at the boundary edge): 0 if bank[6]=1 and bank not 7E/7F, or if bank[6]=0 and addr[15]=1; else 1.
- Strobes:
  - On the edge where t becomes P, READ_OUT (read) or WRITE_OUT (write) goes 0.
  - Both return to 1 on the next boundary edge.
  - Address setup is exactly P CLKs.
- Write data: DATA_OUT = latched WDATA from the boundary edge. DATA_OE=1 for t in [P, L-1]; 0 otherwise.
- Read data: SNES_DATA_IN is sampled on the boundary edge that ends a read cycle (the value present during t=L-1) into RDATA.
- DONE: 1 in the CLK after that ending boundary edge, for one CLK, for both read and write. BUSY drops on the same edge unless a new request is latched.
- Back-to-back: if REQ=1 at the ending boundary edge, the next access starts immediately with no idle cycle; ACK and DONE are asserted in the same CLK.
- REQ rising mid-cycle waits for the next boundary. REQ withdrawn before a boundary starts no access. Request inputs changing after ACK are ignored.
- RST mid-cycle aborts: the next CLK shows reset values, and DONE is never produced for the aborted access.
- No combinational path from any input to any output.

Test Plan:
- Reset + idle (P=4): RST high 3 CLK -> reset values. After release, idle cycles with CPU_CLK period 32 CLK (16 low/16 high), strobes stay 1, CS_OUT=1.
- Read, speed 00, addr 00:8000, responder drives 0xA5 -> ACK, CS_OUT=0, READ_OUT=0 for t=4..23 (20 CLK), DONE 24 CLK after ACK, RDATA=0xA5, CPU_CLK low 8/high 16.
- Write, speed 10, addr 7E:0010, data 0x3C -> CS_OUT=1, WRITE_OUT=0 and DATA_OE=1 for 44 CLK, DATA_OUT=0x3C, DONE once, RDATA unchanged.
- Back-to-back: REQ held for reads at C0:0000 then 40:1234 -> second ACK coincides with first DONE, no idle cycle between, addresses in order.
- Reset mid-access at t=10 of a read -> reset values next CLK, no DONE, BUSY=0, idle cycles resume.
- Speed 11 -> L=32. A REQ pulse raised at t=5 and dropped at t=9 -> no ACK, no strobe.
